// File: rtl/tune_pkg.sv
// rtl/tune_pkg.sv - shared note type, field widths and sequencer states
package tune_pkg;
    localparam int FREQ_W = 10;
    localparam int DUR_W  = 10;

    typedef struct packed {
        logic [FREQ_W-1:0] freq;
        logic [DUR_W-1:0]  dur;
    } note_t;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
endpackage

// File: rtl/tune_sequencer_if.sv
// rtl/tune_sequencer_if.sv - note handshake between tune generator and sequencer
interface tune_sequencer_if;
    import tune_pkg::*;

    logic              note_valid;
    logic              note_ready;
    logic [FREQ_W-1:0] note_freq;
    logic [DUR_W-1:0]  note_dur;

    modport master (output note_valid, note_freq, note_dur, input note_ready);
    modport slave  (input note_valid, note_freq, note_dur, output note_ready);
endinterface

// File: rtl/tune_sequencer_note_fifo.sv
// rtl/tune_sequencer_note_fifo.sv - power-of-two note FIFO with synchronous flush
module note_fifo
    import tune_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  note_t                  din,
    output note_t                  dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    note_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/tune_sequencer.sv
// rtl/tune_sequencer.sv - queues notes and plays them as a square wave with gaps
module tune_sequencer
    import tune_pkg::*;
#(
    parameter int CLK_HZ           = 48_000_000,
    parameter int TICKS_PER_MS     = CLK_HZ / 1000,
    parameter int ACC_W            = 32,
    parameter int PHASE_INC_PER_HZ = 89,
    parameter int DEPTH            = 8,
    parameter int GAP_MS           = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    tune_sequencer_if.slave        note,
    input  logic                   abort,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy,
    output logic                   song
);
    localparam int MS_W = $clog2(TICKS_PER_MS + 1);

    state_t            state, state_next;
    note_t             head;
    logic              full, empty, pop;
    logic [FREQ_W-1:0] freq_q;
    logic [DUR_W-1:0]  dur_cnt;
    logic [MS_W-1:0]   ms_cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  inc;
    logic              tick, last;

    note_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (abort),
        .push  (note.note_valid),
        .pop   (pop),
        .din   ('{freq: note.note_freq, dur: note.note_dur}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign note.note_ready = !full;
    assign busy = (state != IDLE);
    // Truncating operands first keeps the product exact modulo 2^ACC_W.
    assign inc  = ACC_W'(freq_q) * ACC_W'(PHASE_INC_PER_HZ);
    assign tick = (ms_cnt == MS_W'(TICKS_PER_MS - 1));
    assign last = tick && (dur_cnt == DUR_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    pop = 1'b1;
                    if (head.dur != '0) state_next = PLAY;
                end
                PLAY:    if (last) state_next = (GAP_MS > 0) ? GAP : IDLE;
                GAP:     if (last) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // dur_cnt is reloaded with GAP_MS on the last PLAY tick so GAP reuses the ms counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            freq_q  <= '0;
            dur_cnt <= '0;
            ms_cnt  <= '0;
            acc     <= '0;
            song    <= 1'b0;
        end else if (abort) begin
            dur_cnt <= '0;
            ms_cnt  <= '0;
            acc     <= '0;
            song    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    song <= 1'b0;
                    if (pop) begin
                        freq_q  <= head.freq;
                        dur_cnt <= head.dur;
                        ms_cnt  <= '0;
                        acc     <= '0;
                    end
                end
                PLAY: begin
                    acc  <= acc + inc;
                    song <= (freq_q != '0) && acc[ACC_W-1];
                    if (tick) begin
                        ms_cnt  <= '0;
                        dur_cnt <= last ? DUR_W'(GAP_MS) : dur_cnt - 1'b1;
                    end else begin
                        ms_cnt <= ms_cnt + 1'b1;
                    end
                end
                GAP: begin
                    song <= 1'b0;
                    if (tick) begin
                        ms_cnt  <= '0;
                        dur_cnt <= dur_cnt - 1'b1;
                    end else begin
                        ms_cnt <= ms_cnt + 1'b1;
                    end
                end
                default: song <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_tune_sequencer.sv
// tb/tb_tune_sequencer.sv - self-checking bench for tune_sequencer
module tb_tune_sequencer;
    import tune_pkg::*;

    localparam int T     = 10;
    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       abort;
    logic [2:0] fifo_count;
    logic       busy;
    logic       song;

    tune_sequencer_if nif ();

    tune_sequencer #(
        .CLK_HZ(10_000), .TICKS_PER_MS(T), .ACC_W(AW),
        .PHASE_INC_PER_HZ(1), .DEPTH(DEPTH), .GAP_MS(GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .note       (nif),
        .abort      (abort),
        .fifo_count (fifo_count),
        .busy       (busy),
        .song       (song)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a note occupies (dur+GAP)*T cycles after its pop; during its first dur*T
    // cycles the tone is the MSB of (elapsed*freq mod 2^AW), seen one cycle later on song.
    typedef struct {int freq; int dur;} mnote_t;
    mnote_t mq[$];
    bit     m_active;
    int     m_freq, m_dur, m_el;
    bit     m_song;

    function automatic void model_reset();
        mq.delete();
        m_active = 0; m_el = 0; m_freq = 0; m_dur = 0; m_song = 0;
    endfunction

    function automatic void model_edge(bit v, int f, int d, bit ab);
        bit     accepted;
        mnote_t h;
        accepted = v && (mq.size() < DEPTH) && !ab;
        if (ab) begin
            mq.delete();
            m_active = 0;
            m_song   = 0;
            return;
        end
        m_song = m_active && (m_el < m_dur * T) && (m_freq != 0)
                 && (((m_el * m_freq) % (1 << AW)) >= (1 << (AW - 1)));
        if (!m_active) begin
            if (mq.size() > 0) begin
                h = mq.pop_front();
                if (h.dur != 0) begin
                    m_active = 1; m_el = 0; m_freq = h.freq; m_dur = h.dur;
                end
            end
        end else begin
            m_el++;
            if (m_el == (m_dur + GAP) * T) m_active = 0;
        end
        if (accepted) mq.push_back('{f, d});
    endfunction

    // Called at a negedge; returns at the following negedge with outputs checked.
    task automatic cyc(input bit v, input int f, input int d, input bit ab);
        nif.note_valid = v;
        nif.note_freq  = 10'(f);
        nif.note_dur   = 10'(d);
        abort          = ab;
        check("note_ready", nif.note_ready, mq.size() < DEPTH);
        @(posedge clk);
        model_edge(v, f, d, ab);
        @(negedge clk);
        check("busy", busy, m_active);
        check("song", song, m_song);
        check("fifo_count", fifo_count, mq.size());
    endtask

    task automatic drain();
        for (int i = 0; i < 600 && (m_active || mq.size() > 0); i++) cyc(0, 0, 0, 0);
        check("drain_busy", busy, 0);
    endtask

    typedef struct {int freq; int dur; int exp_busy; int exp_high;} vec_t;
    vec_t tbl[7];

    initial begin
        int nb, nh;

        tbl[0] = '{16, 3, 50, 14};
        tbl[1] = '{32, 1, 30, 4};
        tbl[2] = '{0, 2, 40, 0};
        tbl[3] = '{64, 1, 30, 4};
        tbl[4] = '{200, 1, 30, 4};
        tbl[5] = '{16, 0, 0, 0};
        tbl[6] = '{3, 5, 70, 7};

        reset = 1'b1; abort = 1'b0;
        nif.note_valid = 1'b0; nif.note_freq = '0; nif.note_dur = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_song", song, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", nif.note_ready, 1);
        reset = 1'b0;

        // Single notes: busy length and number of high song cycles per note.
        for (int i = 0; i < 7; i++) begin
            nb = 0; nh = 0;
            cyc(1, tbl[i].freq, tbl[i].dur, 0);
            for (int k = 0; k < 80; k++) begin
                cyc(0, 0, 0, 0);
                nb += int'(busy);
                nh += int'(song);
            end
            check($sformatf("tbl%0d_busy_cycles", i), nb, tbl[i].exp_busy);
            check($sformatf("tbl%0d_high_cycles", i), nh, tbl[i].exp_high);
        end

        // Latency: count=1 and busy=0 after the push edge, busy=1 after the pop edge.
        cyc(1, 16, 3, 0);
        check("lat_count_push", fifo_count, 1);
        check("lat_busy_push", busy, 0);
        cyc(0, 0, 0, 0);
        check("lat_busy_pop", busy, 1);
        check("lat_count_pop", fifo_count, 0);

        // Full FIFO: four more notes fit while playing, the fifth waits for a pop.
        for (int i = 0; i < 4; i++) cyc(1, 8 * (i + 1), 1, 0);
        check("full_ready", nif.note_ready, 0);
        check("full_count", fifo_count, 4);
        for (int i = 0; i < 60 && mq.size() == DEPTH; i++) cyc(1, 48, 1, 0);
        check("fifth_waiting", mq.size() == DEPTH, 0);
        cyc(1, 48, 1, 0);
        drain();

        // Rest then short tone; zero-length note then tone.
        cyc(1, 0, 2, 0);
        cyc(1, 32, 1, 0);
        drain();
        cyc(1, 16, 0, 0);
        cyc(1, 16, 1, 0);
        drain();

        // Abort mid-PLAY with two queued and a push in the same cycle.
        cyc(1, 16, 3, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 40, 2, 0);
        cyc(1, 50, 2, 0);
        repeat (12) cyc(0, 0, 0, 0);
        cyc(1, 99, 1, 1);
        check("abort_song", song, 0);
        check("abort_busy", busy, 0);
        check("abort_count", fifo_count, 0);
        repeat (20) cyc(0, 0, 0, 0);
        check("abort_push_dropped", busy, 0);

        // Asynchronous reset between edges mid-PLAY.
        cyc(1, 16, 3, 0);
        cyc(1, 20, 1, 0);
        cyc(1, 24, 1, 0);
        repeat (15) cyc(0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("areset_song", song, 0);
        check("areset_busy", busy, 0);
        check("areset_count", fifo_count, 0);
        check("areset_ready", nif.note_ready, 1);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Random traffic against the reference.
        for (int i = 0; i < 4000; i++)
            cyc(1'($urandom_range(0, 1)), $urandom_range(0, 1023),
                $urandom_range(0, 3), $urandom_range(0, 149) == 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
